// File: rtl/reg_file_pkg.sv
// Shared constants for the CPU register file:
// register indices, write-mode encodings and storage size.
package reg_file_pkg;

  localparam int NREGS = 11;

  localparam logic [3:0] REG_B     = 4'd0;
  localparam logic [3:0] REG_C     = 4'd1;
  localparam logic [3:0] REG_D     = 4'd2;
  localparam logic [3:0] REG_E     = 4'd3;
  localparam logic [3:0] REG_H     = 4'd4;
  localparam logic [3:0] REG_L     = 4'd5;
  localparam logic [3:0] REG_SP_HI = 4'd6;
  localparam logic [3:0] REG_SP_LO = 4'd7;
  localparam logic [3:0] REG_PC_HI = 4'd8;
  localparam logic [3:0] REG_PC_LO = 4'd9;
  localparam logic [3:0] REG_A     = 4'd10;

  localparam logic [3:0] LAST_REG = 4'(NREGS - 1);

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_BYTE = 2'b01;
  localparam logic [1:0] WE_PAIR = 2'b10;

  typedef logic [NREGS-1:0][7:0] regs_t;

  function automatic logic byte_ok(
    input logic [3:0] idx
  );
    return idx <= LAST_REG;
  endfunction

  // A pair needs an even high index whose partner still exists.
  function automatic logic pair_ok(
    input logic [3:0] idx
  );
    return !idx[0] && (idx < LAST_REG);
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Decode/control side bundle of the register file:
// write port, flag write port and the two read ports.
interface reg_file_if;
  logic [1:0]  writeEn;
  logic        writeFlag;
  logic [3:0]  wrReg;
  logic [15:0] wrData;
  logic [7:0]  flagData;
  logic [3:0]  rdReg1;
  logic [7:0]  rdData1;
  logic [7:0]  rdData1Lo;
  logic [3:0]  rdReg2;
  logic [7:0]  rdData2;
  logic [7:0]  rdData2Lo;
  logic [7:0]  rdFlag;

  modport master (
    output writeEn, writeFlag, wrReg,
    output wrData, flagData,
    output rdReg1, rdReg2,
    input  rdData1, rdData1Lo,
    input  rdData2, rdData2Lo,
    input  rdFlag
  );

  modport slave (
    input  writeEn, writeFlag, wrReg,
    input  wrData, flagData,
    input  rdReg1, rdReg2,
    output rdData1, rdData1Lo,
    output rdData2, rdData2Lo,
    output rdFlag
  );
endinterface

// File: rtl/reg_file_rdport.sv
// One combinational read port: indexed byte plus its
// pair partner, zero when either index is out of range.
module reg_file_rdport
  import reg_file_pkg::*;
(
  input  regs_t      regs,
  input  logic [3:0] idx,
  output logic [7:0] hi,
  output logic [7:0] lo
);

  always_comb begin
    hi = '0;
    lo = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx == 4'(i)) hi = regs[i];
    end
    for (int i = 1; i < NREGS; i++) begin
      if (idx == 4'(i - 1)) lo = regs[i];
    end
  end

endmodule

// File: rtl/reg_file.sv
// Game Boy style register file: 11 bytes, a flag
// register, byte/pair write port and two read ports.
module reg_file
  import reg_file_pkg::*;
(
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  regs_t      regs;
  logic [7:0] flag;
  logic       byte_we;
  logic       pair_we;

  always_comb begin
    byte_we = 1'b0;
    pair_we = 1'b0;
    unique case (1'b1)
      bus.writeEn == WE_BYTE: byte_we = byte_ok(bus.wrReg);
      bus.writeEn == WE_PAIR: pair_we = pair_ok(bus.wrReg);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs <= '0;
      flag <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (byte_we && bus.wrReg == 4'(i))
          regs[i] <= bus.wrData[7:0];
        if (pair_we && bus.wrReg == 4'(i))
          regs[i] <= bus.wrData[15:8];
      end
      for (int i = 1; i < NREGS; i++) begin
        if (pair_we && bus.wrReg == 4'(i - 1))
          regs[i] <= bus.wrData[7:0];
      end
      if (bus.writeFlag)
        flag <= bus.flagData;
    end
  end

  reg_file_rdport u_rd1 (
    .regs (regs),
    .idx  (bus.rdReg1),
    .hi   (bus.rdData1),
    .lo   (bus.rdData1Lo)
  );

  reg_file_rdport u_rd2 (
    .regs (regs),
    .idx  (bus.rdReg2),
    .hi   (bus.rdData2),
    .lo   (bus.rdData2Lo)
  );

  assign bus.rdFlag = flag;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed cases
// plus random traffic against a byte-array model.
module tb_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] m [0:10];
  logic [7:0] mf;
  bit         en = 1'b0;
  int         ncmp = 0;
  int         nerr = 0;

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd_hi(input logic [3:0] i);
    return (i <= 4'd10) ? m[i] : 8'h00;
  endfunction

  function automatic logic [7:0] rd_lo(input logic [3:0] i);
    return (i <= 4'd9) ? m[i + 4'd1] : 8'h00;
  endfunction

  task automatic drive(input logic r,
                       input logic [1:0] we,
                       input logic wf,
                       input logic [3:0] wr,
                       input logic [15:0] wd,
                       input logic [7:0] fd);
    rst           = r;
    bus.writeEn   = we;
    bus.writeFlag = wf;
    bus.wrReg     = wr;
    bus.wrData    = wd;
    bus.flagData  = fd;
  endtask

  // Apply the model rules at the edge, then settle.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      foreach (m[i]) m[i] = 8'h00;
      mf = 8'h00;
    end else begin
      if (bus.writeEn == 2'b01 && bus.wrReg <= 4'd10)
        m[bus.wrReg] = bus.wrData[7:0];
      if (bus.writeEn == 2'b10 && bus.wrReg <= 4'd8
          && bus.wrReg[0] == 1'b0) begin
        m[bus.wrReg]        = bus.wrData[15:8];
        m[bus.wrReg + 4'd1] = bus.wrData[7:0];
      end
      if (bus.writeFlag) mf = bus.flagData;
    end
    #1;
  endtask

  task automatic rd(input logic [3:0] a,
                    input logic [3:0] b);
    bus.rdReg1 = a;
    bus.rdReg2 = b;
    #1;
  endtask

  always @(negedge clk) begin
    if (en) begin
      chk("cyc_rd1",   bus.rdData1,   rd_hi(bus.rdReg1));
      chk("cyc_rd1lo", bus.rdData1Lo, rd_lo(bus.rdReg1));
      chk("cyc_rd2",   bus.rdData2,   rd_hi(bus.rdReg2));
      chk("cyc_rd2lo", bus.rdData2Lo, rd_lo(bus.rdReg2));
      chk("cyc_flag",  bus.rdFlag,    mf);
    end
  end

  initial begin
    drive(1'b0, 2'b01, 1'b1, 4'd3, 16'hFFFF, 8'hFF);
    bus.rdReg1 = 4'd0;
    bus.rdReg2 = 4'd1;
    repeat (5) tick();
    en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      rd(4'(i), 4'(i));
      chk("rst_rd1", bus.rdData1, 8'h00);
      chk("rst_rd1lo", bus.rdData1Lo, 8'h00);
    end
    chk("rst_flag", bus.rdFlag, 8'h00);

    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 2'b01, 1'b0, 4'(i), 16'(i) | 16'hEE00, 8'h00);
      tick();
    end
    drive(1'b1, 2'b00, 1'b0, 4'd0, 16'h0, 8'h00);
    for (int i = 0; i <= 10; i += 2) begin
      rd(4'(i), 4'(i));
      chk("byte_rd1", bus.rdData1, 8'(i));
      chk("byte_rd1lo", bus.rdData1Lo,
          (i == 10) ? 8'h00 : 8'(i + 1));
      chk("byte_rd2", bus.rdData2, 8'(i));
      chk("byte_rd2lo", bus.rdData2Lo,
          (i == 10) ? 8'h00 : 8'(i + 1));
    end
    rd(4'd11, 4'd15);
    chk("oob_rd1", bus.rdData1, 8'h00);
    chk("oob_rd2lo", bus.rdData2Lo, 8'h00);

    drive(1'b1, 2'b10, 1'b0, 4'd4, 16'hABCD, 8'h00);
    tick();
    rd(4'd4, 4'd3);
    chk("pair_hi", bus.rdData1, 8'hAB);
    chk("pair_lo", bus.rdData1Lo, 8'hCD);
    chk("pair_e_lo", bus.rdData2Lo, 8'hAB);

    drive(1'b1, 2'b10, 1'b0, 4'd5, 16'h1111, 8'h00);
    tick();
    drive(1'b1, 2'b10, 1'b0, 4'd10, 16'h2222, 8'h00);
    tick();
    drive(1'b1, 2'b01, 1'b0, 4'd12, 16'h3333, 8'h00);
    tick();
    drive(1'b1, 2'b11, 1'b0, 4'd0, 16'h4444, 8'h00);
    tick();
    rd(4'd4, 4'd10);
    chk("ill_h", bus.rdData1, 8'hAB);
    chk("ill_l", bus.rdData1Lo, 8'hCD);
    chk("ill_a", bus.rdData2, 8'h0A);
    rd(4'd0, 4'd5);
    chk("ill_b", bus.rdData1, 8'h00);
    chk("ill_c", bus.rdData1Lo, 8'h01);
    chk("ill_l2", bus.rdData2, 8'hCD);
    chk("ill_6", bus.rdData2Lo, 8'h06);

    drive(1'b1, 2'b00, 1'b1, 4'd0, 16'h0, 8'h78);
    tick();
    chk("flag_78", bus.rdFlag, 8'd120);
    drive(1'b1, 2'b00, 1'b1, 4'd0, 16'h0, 8'h00);
    tick();
    chk("flag_00", bus.rdFlag, 8'h00);

    drive(1'b1, 2'b01, 1'b1, 4'd3, 16'h005A, 8'hA5);
    tick();
    rd(4'd3, 4'd2);
    chk("both_e", bus.rdData1, 8'h5A);
    chk("both_flag", bus.rdFlag, 8'hA5);

    rd(4'd2, 4'd2);
    drive(1'b1, 2'b01, 1'b0, 4'd2, 16'h0077, 8'h00);
    #1;
    chk("rdw_old", bus.rdData1, 8'h02);
    tick();
    chk("rdw_new", bus.rdData1, 8'h77);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) != 0),
            2'($urandom), 1'($urandom),
            4'($urandom_range(0, 12)),
            16'($urandom), 8'($urandom));
      bus.rdReg1 = 4'($urandom_range(0, 12));
      bus.rdReg2 = 4'($urandom_range(0, 12));
      tick();
    end

    drive(1'b1, 2'b10, 1'b1, 4'd0, 16'h1234, 8'h99);
    tick();
    rd(4'd0, 4'd0);
    chk("pre_rst_b", bus.rdData1, 8'h12);
    chk("pre_rst_f", bus.rdFlag, 8'h99);
    drive(1'b0, 2'b01, 1'b1, 4'd0, 16'h5555, 8'h66);
    tick();
    for (int i = 0; i < 11; i++) begin
      rd(4'(i), 4'(10 - i));
      chk("mid_rst_rd1", bus.rdData1, 8'h00);
      chk("mid_rst_rd2", bus.rdData2, 8'h00);
    end
    chk("mid_rst_flag", bus.rdFlag, 8'h00);
    drive(1'b1, 2'b00, 1'b0, 4'd0, 16'h0, 8'h00);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
